// File: rtl/lab5_pio_pkg.sv
// Shared definitions for the Lab5 Nios II key/switch input PIO: register map
// addresses, edge-type encodings and a counter-width helper.
package lab5_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISING  = 2'd0,
        EDGE_FALLING = 2'd1,
        EDGE_ANY     = 2'd2
    } edge_type_e;

    // Debounce counter width: clog2(cycles+1), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input line: 2-FF synchronizer, stability counter and debounced register,
// with single-cycle pulses announcing that the debounced value changes this edge.
module pio_debounce_bit
    import lab5_pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter logic        IDLE            = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic deb,
    output logic update,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned LAST = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        sync1_d = in_bit;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(LAST)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= IDLE;
            sync2_q <= IDLE;
            deb_q   <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb    = deb_q;
    assign update = (deb_d != deb_q);
    assign rise   = update & deb_d;
    assign fall   = update & ~deb_d;

endmodule

// File: rtl/lab5_nios_key_pio.sv
// Avalon-MM input PIO for push-buttons/switches: per-bit debounce, edge capture
// with write-1-to-clear, interrupt mask and a registered 4-word read port.
module lab5_nios_key_pio
    import lab5_pio_pkg::*;
#(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 0,
    parameter int unsigned      EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] EDGE_SEL = EDGE_TYPE[1:0];

    logic [WIDTH-1:0] deb, update, rise, fall, edge_event, clr;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .IDLE           (IDLE_LEVEL[i])
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .in_bit(in_port[i]),
            .deb   (deb[i]),
            .update(update[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    assign wr_en        = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        case (EDGE_SEL)
            EDGE_RISING:  edge_event = rise;
            EDGE_FALLING: edge_event = fall;
            default:      edge_event = update;
        endcase

        clr       = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
        // A fresh edge beats a clear on the same bit.
        edgecap_d = (edgecap_q & ~clr) | edge_event;

        irqmask_d = irqmask_q;
        if (wr_en && address == ADDR_IRQMASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end

        irq_d = |(edgecap_d & irqmask_d);

        readdata_d = '0;
        if (chipselect) begin
            case (address)
                ADDR_DATA:    readdata_d = 32'(deb);
                ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
                ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
                default:      readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_lab5_nios_key_pio.sv
// Directed bench for lab5_nios_key_pio: three instances (no debounce/falling,
// 4-cycle debounce/falling, no debounce/any edge) share one stimulus bus.
module tb_lab5_nios_key_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;

    logic [31:0] rd0, rd4, rd2;
    logic        irq0, irq4, irq2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lab5_nios_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in_port), .irq(irq0)
    );

    lab5_nios_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut4 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd4),
        .in_port(in_port), .irq(irq4)
    );

    lab5_nios_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2),
        .in_port(in_port), .irq(irq2)
    );

    typedef struct {
        logic [3:0]  in;
        logic        cs;
        logic        wn;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        irq;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        idle_bus();
    endtask

    task automatic bus_read(input logic [1:0] a);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        tick();
        idle_bus();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle_bus();
        in_port = 4'hF;
        do_reset();
        check("reset_rd0", rd0, 32'h0);
        check("reset_irq0", 32'(irq0), 32'h0);

        // Cycle-by-cycle vectors for dut0: mask bit 0, falling edge on bit 0,
        // W1C clear, rising edge ignored, data writes ignored, reserved reads 0.
        tbl[0]  = '{4'hF, 1'b1, 1'b1, 2'd0, 32'h0,        32'h0000000F, 1'b0};
        tbl[1]  = '{4'hF, 1'b1, 1'b0, 2'd2, 32'h1,        32'h00000000, 1'b0};
        tbl[2]  = '{4'hE, 1'b0, 1'b1, 2'd0, 32'h0,        32'h00000000, 1'b0};
        tbl[3]  = '{4'hE, 1'b0, 1'b1, 2'd0, 32'h0,        32'h00000000, 1'b0};
        tbl[4]  = '{4'hE, 1'b1, 1'b1, 2'd0, 32'h0,        32'h0000000F, 1'b1};
        tbl[5]  = '{4'hE, 1'b1, 1'b1, 2'd3, 32'h0,        32'h00000001, 1'b1};
        tbl[6]  = '{4'hE, 1'b1, 1'b1, 2'd0, 32'h0,        32'h0000000E, 1'b1};
        tbl[7]  = '{4'hE, 1'b1, 1'b0, 2'd3, 32'h1,        32'h00000001, 1'b0};
        tbl[8]  = '{4'hE, 1'b1, 1'b1, 2'd3, 32'h0,        32'h00000000, 1'b0};
        tbl[9]  = '{4'hF, 1'b1, 1'b1, 2'd1, 32'h0,        32'h00000000, 1'b0};
        tbl[10] = '{4'hF, 1'b1, 1'b0, 2'd0, 32'hFFFFFFFF, 32'h0000000E, 1'b0};
        tbl[11] = '{4'hF, 1'b1, 1'b1, 2'd0, 32'h0,        32'h0000000E, 1'b0};
        tbl[12] = '{4'hF, 1'b1, 1'b1, 2'd0, 32'h0,        32'h0000000F, 1'b0};
        tbl[13] = '{4'hF, 1'b1, 1'b1, 2'd3, 32'h0,        32'h00000000, 1'b0};

        for (int i = 0; i < 14; i++) begin
            in_port    = tbl[i].in;
            chipselect = tbl[i].cs;
            write_n    = tbl[i].wn;
            address    = tbl[i].addr;
            writedata  = tbl[i].wd;
            tick();
            check($sformatf("vec%0d_rd", i), rd0, tbl[i].rd);
            check($sformatf("vec%0d_irq", i), 32'(irq0), 32'(tbl[i].irq));
        end
        idle_bus();

        // Clear coinciding with a new falling edge on bit 0: the edge wins.
        in_port = 4'hE;
        tick();
        tick();
        bus_write(2'd3, 32'h1);
        check("edge_beats_clear_irq", 32'(irq0), 32'h1);
        bus_read(2'd3);
        check("edge_beats_clear_cap", rd0, 32'h1);

        // Masking a pending capture drops irq; unmasking raises it next edge.
        bus_write(2'd2, 32'h0);
        check("masked_irq", 32'(irq0), 32'h0);
        bus_read(2'd3);
        check("masked_cap_kept", rd0, 32'h1);
        bus_write(2'd2, 32'hF);
        check("unmask_irq", 32'(irq0), 32'h1);
        bus_read(2'd2);
        check("mask_readback", rd0, 32'hF);

        // dut4: a 3-cycle low glitch on bit 1 never reaches deb.
        in_port = 4'hF;
        do_reset();
        bus_write(2'd2, 32'hF);
        in_port = 4'hD;
        repeat (3) tick();
        in_port = 4'hF;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("glitch_irq%0d", i), 32'(irq4), 32'h0);
        end
        bus_read(2'd0);
        check("glitch_data", rd4, 32'hF);
        bus_read(2'd3);
        check("glitch_cap", rd4, 32'h0);

        // dut4: a 4-cycle low level is accepted exactly at k+5.
        in_port = 4'hD;
        repeat (5) tick();
        check("deb4_irq_k4", 32'(irq4), 32'h0);
        tick();
        check("deb4_irq_k5", 32'(irq4), 32'h1);
        bus_read(2'd0);
        check("deb4_data", rd4, 32'hD);
        bus_read(2'd3);
        check("deb4_cap", rd4, 32'h2);

        // Reset in the middle of a debounce count.
        in_port = 4'hF;
        repeat (3) tick();
        reset      = 1'b1;
        chipselect = 1'b1;
        address    = 2'd0;
        tick();
        check("midreset_rd", rd4, 32'h0);
        check("midreset_irq", 32'(irq4), 32'h0);
        reset = 1'b0;
        idle_bus();
        bus_read(2'd3);
        check("midreset_cap", rd4, 32'h0);
        bus_read(2'd0);
        check("midreset_data", rd4, 32'hF);
        bus_read(2'd2);
        check("midreset_mask", rd4, 32'h0);

        // dut2: both transitions on bit 3 are captured.
        do_reset();
        bus_write(2'd2, 32'h8);
        in_port = 4'h7;
        tick();
        tick();
        check("any_fall_k1", 32'(irq2), 32'h0);
        tick();
        check("any_fall_irq", 32'(irq2), 32'h1);
        bus_read(2'd3);
        check("any_fall_cap", rd2, 32'h8);
        bus_write(2'd3, 32'h8);
        check("any_clear_irq", 32'(irq2), 32'h0);
        in_port = 4'hF;
        repeat (3) tick();
        check("any_rise_irq", 32'(irq2), 32'h1);
        bus_read(2'd3);
        check("any_rise_cap", rd2, 32'h8);
        bus_read(2'd1);
        check("any_rsvd", rd2, 32'h0);
        tick();
        check("rd_idle_zero", rd2, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lab5_nios_key_pio.md
Name: lab5_nios_key_pio

Overview:
- Avalon-MM slave input PIO: the receive-direction counterpart of the LED output PIO.
- Samples asynchronous push-button/switch lines through a 2-FF synchronizer, an optional per-bit debouncer and an edge-capture register.
- Exposes the lines to the Nios II through a 4-word register map and raises a level interrupt on unmasked captured edges.
- Sits in the Lab5_nios system next to the LED PIO, on the same clock domain.

Parameters:
- WIDTH, 4, number of input lines (1..32).
- DEBOUNCE_CYCLES, 0, consecutive stable cycles before the debounced value follows the input. 0 and 1 behave identically.
- EDGE_TYPE, 1, edge that sets edgecapture: 0 rising, 1 falling, 2 any.
- IDLE_LEVEL, all-ones (WIDTH bits), reset value of the synchronizer and debounced registers (KEY lines are active-low).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- address  input  2  word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- in_port  input  WIDTH  asynchronous external inputs.
- irq  output  1  level interrupt to the CPU.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values:
  - sync1, sync2 and deb = IDLE_LEVEL.
  - Debounce counters = 0.
  - irqmask = 0, edgecapture = 0.
  - readdata = 0, irq = 0.
- Reset asserted mid-operation returns every register to these values on the next edge. Pending edges are lost.
- Synchronizer: sync1 <= in_port; sync2 <= sync1.
- Debounce, per bit:
  - When sync2 == deb, the counter clears.
  - Otherwise the counter increments. When it already equals DEBOUNCE_CYCLES-1, deb <= sync2 and the counter clears instead.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches deb.
  - Counter width: clog2(DEBOUNCE_CYCLES+1), minimum 1.
- Latency: an input level first sampled at edge k appears in deb at edge k+1+max(DEBOUNCE_CYCLES,1).
- Edge event for bit i: deb[i] is updating this edge AND the transition matches EDGE_TYPE.
- Register map (32-bit words; unused upper bits read 0):
  - 0 data: RO, reads deb. Writes ignored.
  - 1 reserved: reads 0. Writes ignored.
  - 2 irqmask: RW, WIDTH bits. Write when chipselect && !write_n.
  - 3 edgecapture: read returns captured bits. Write-1-to-clear per bit.
- edgecapture per bit: set on edge event, else clear on a W1C write with writedata[i]=1, else hold. A simultaneous edge event and clear on the same bit leaves the bit set (edge wins).
- Read: readdata <= register selected by address when chipselect = 1, else 0. Read latency is 1 cycle (fixed); there is no waitrequest.
- irq: registered; irq <= |(edgecapture_next & irqmask_next). It therefore asserts on the same edge the capture bit sets and deasserts on the edge that clears the last unmasked bit or masks it.
- A write to address 0 or 1 has no side effects.

Decomposition:
- Shared package (lab5_pio_pkg):
  - address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings.
- Sub-module pio_debounce_bit: one bit of synchronizer, counter and deb register, plus an update/rise/fall pulse. Instantiated WIDTH times by generate.
- The top level holds the register file, the edge logic, readdata and irq.

Test Plan:
- Reset with in_port=4'hF, then read address 0 -> readdata=32'h0000000F one cycle after the request; irq=0, edgecapture=0.
- DEBOUNCE_CYCLES=0, EDGE_TYPE=1, mask=4'h1; drive in_port=4'hE at edge k -> deb=4'hE and edgecapture=4'h1 at k+2; irq=1 at k+2.
- Write 32'h1 to address 3 -> edgecapture=0 and irq=0 at the next edge. Repeat the clear on the same edge as a new falling edge on bit 0 -> bit stays 1.
- DEBOUNCE_CYCLES=4: pulse bit 1 low for 3 cycles -> deb and edgecapture unchanged. Hold low 4 cycles -> deb[1]=0 at k+5, edgecapture=4'h2.
- mask=0 with an edge captured -> irq=0. Write mask=4'hF -> irq=1 next edge. Assert reset mid-debounce -> all outputs at reset values next edge.
- EDGE_TYPE=2: toggle bit 3 high->low->high with clears in between -> capture on both transitions. Reads of address 1 return 0; writes to address 0 do not change readdata.
